// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, fetch FSM encoding and reset PC default for ifetch
package ifetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_MISS    = 2'd1,
    F_HOLD    = 2'd2,
    F_DISCARD = 2'd3
  } fstate_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/ifetch_icache.sv
// rtl/ifetch_icache.sv - direct-mapped one-word-per-line instruction cache
// Combinational lookup, synchronous fill, valid bits cleared by active-low rst.
module ifetch_icache
  import ifetch_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:2] lookup_addr,
  output logic              hit,
  output logic [INST_W-1:0] hit_inst,
  input  logic              fill_en,
  input  logic [ADDR_W-1:2] fill_addr,
  input  logic [INST_W-1:0] fill_data
);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - 2 - IW;

  logic [INST_W-1:0] data_q [LINES];
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] rd_tag;
  logic [TW-1:0] wr_tag;

  assign rd_idx = lookup_addr[IW+1:2];
  assign rd_tag = lookup_addr[ADDR_W-1:IW+2];
  assign wr_idx = fill_addr[IW+1:2];
  assign wr_tag = fill_addr[ADDR_W-1:IW+2];

  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign hit_inst = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[wr_idx] <= fill_data;
      tag_q[wr_idx]  <= wr_tag;
    end
  end
endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: PC, memory fetch FSM, decoder handshake
// Optional instruction cache enabled by defining ICACHE_EN.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                ICACHE_LINES = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              oMC_en,
  output logic [ADDR_W-1:0] oMC_addr,
  input  logic              iMC_done,
  input  logic [INST_W-1:0] iMC_inst,
  input  logic              iBP_taken,
  input  logic [ADDR_W-1:0] iBP_target,
  output logic              oID_valid,
  output logic [INST_W-1:0] oID_inst,
  output logic [ADDR_W-1:0] oID_pc,
  output logic              oID_pred,
  input  logic              iID_ready,
  input  logic              iJP_en,
  input  logic [ADDR_W-1:0] iJP_pc
);
  if ((ICACHE_LINES < 2) || (ICACHE_LINES > 1024) ||
      ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two in 2..1024");
  end

  fstate_t           state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              en_n, valid_n;
  logic [ADDR_W-1:0] addr_n, idpc_n;
  logic [INST_W-1:0] inst_n;
  logic              hit;
  logic [INST_W-1:0] hit_inst;

`ifdef ICACHE_EN
  logic fill_en;
  // In MISS the request address equals pc; in DISCARD it is the stale one.
  assign fill_en = rdy && iMC_done && ((state == F_MISS) || (state == F_DISCARD));

  ifetch_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (pc[ADDR_W-1:2]),
    .hit         (hit),
    .hit_inst    (hit_inst),
    .fill_en     (fill_en),
    .fill_addr   (oMC_addr[ADDR_W-1:2]),
    .fill_data   (iMC_inst)
  );
`else
  assign hit      = 1'b0;
  assign hit_inst = '0;
`endif

  assign oID_pred = iBP_taken;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    en_n    = oMC_en;
    addr_n  = oMC_addr;
    valid_n = oID_valid;
    inst_n  = oID_inst;
    idpc_n  = oID_pc;
    if (iJP_en) begin
      pc_n    = word_align(iJP_pc);
      valid_n = 1'b0;
    end
    unique case (state)
      F_IDLE: begin
        if (!iJP_en) begin
          if (hit) begin
            inst_n  = hit_inst;
            idpc_n  = pc;
            valid_n = 1'b1;
            state_n = F_HOLD;
          end else begin
            en_n    = 1'b1;
            addr_n  = pc;
            state_n = F_MISS;
          end
        end
      end
      F_MISS: begin
        if (iMC_done) begin
          en_n = 1'b0;
        end
        if (iJP_en) begin
          state_n = iMC_done ? F_IDLE : F_DISCARD;
        end else if (iMC_done) begin
          inst_n  = iMC_inst;
          idpc_n  = pc;
          valid_n = 1'b1;
          state_n = F_HOLD;
        end
      end
      F_HOLD: begin
        if (iJP_en) begin
          state_n = F_IDLE;
        end else if (iID_ready) begin
          pc_n    = word_align(iBP_taken ? iBP_target : pc + 32'd4);
          valid_n = 1'b0;
          state_n = F_IDLE;
        end
      end
      F_DISCARD: begin
        if (iMC_done) begin
          en_n    = 1'b0;
          state_n = F_IDLE;
        end
      end
      default: state_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= F_IDLE;
      pc        <= word_align(RESET_PC);
      oMC_en    <= 1'b0;
      oMC_addr  <= '0;
      oID_valid <= 1'b0;
      oID_inst  <= '0;
      oID_pc    <= '0;
    end else if (rdy) begin
      state     <= state_n;
      pc        <= pc_n;
      oMC_en    <= en_n;
      oMC_addr  <= addr_n;
      oID_valid <= valid_n;
      oID_inst  <= inst_n;
      oID_pc    <= idpc_n;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed scoreboard bench for ifetch (cache steps under ICACHE_EN)
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        oMC_en;
  logic [31:0] oMC_addr;
  logic        iMC_done;
  logic [31:0] iMC_inst;
  logic        iBP_taken;
  logic [31:0] iBP_target;
  logic        oID_valid;
  logic [31:0] oID_inst, oID_pc;
  logic        oID_pred;
  logic        iID_ready, iJP_en;
  logic [31:0] iJP_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .oMC_en     (oMC_en),
    .oMC_addr   (oMC_addr),
    .iMC_done   (iMC_done),
    .iMC_inst   (iMC_inst),
    .iBP_taken  (iBP_taken),
    .iBP_target (iBP_target),
    .oID_valid  (oID_valid),
    .oID_inst   (oID_inst),
    .oID_pc     (oID_pc),
    .oID_pred   (oID_pred),
    .iID_ready  (iID_ready),
    .iJP_en     (iJP_en),
    .iJP_pc     (iJP_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_en(input int budget);
    int i = 0;
    while (oMC_en !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    if (oMC_en !== 1'b1) chk("en_timeout", {31'b0, oMC_en}, 32'd1);
  endtask

  // Memory model: answer the outstanding request after lat cycles of oMC_en.
  task automatic serve(input logic [31:0] addr, input logic [31:0] inst, input int lat);
    wait_en(20);
    chk("mc_addr", oMC_addr, addr);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("mc_en_hold", {31'b0, oMC_en}, 32'd1);
      chk("mc_addr_hold", oMC_addr, addr);
      chk("no_valid_in_miss", {31'b0, oID_valid}, 32'd0);
    end
    iMC_done = 1'b1;
    iMC_inst = inst;
    sb.push_back('{pc: addr, inst: inst});
    tick();
    iMC_done = 1'b0;
    iMC_inst = '0;
    chk("mc_en_drop", {31'b0, oMC_en}, 32'd0);
  endtask

  task automatic consume(input logic taken, input logic [31:0] target);
    exp_t x;
    int i = 0;
    while (oID_valid !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    chk("id_valid", {31'b0, oID_valid}, 32'd1);
    chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("id_inst", oID_inst, x.inst);
      chk("id_pc", oID_pc, x.pc);
    end
    iBP_taken  = taken;
    iBP_target = target;
    iID_ready  = 1'b1;
    #1;
    chk("id_pred", {31'b0, oID_pred}, {31'b0, taken});
    tick();
    iID_ready  = 1'b0;
    iBP_taken  = 1'b0;
    iBP_target = '0;
    chk("valid_clear", {31'b0, oID_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; iMC_done = 1'b0; iMC_inst = '0;
    iBP_taken = 1'b0; iBP_target = '0; iID_ready = 1'b0; iJP_en = 1'b0; iJP_pc = '0;
    repeat (2) tick();
    chk("rst_mc_en", {31'b0, oMC_en}, 32'd0);
    chk("rst_mc_addr", oMC_addr, 32'd0);
    chk("rst_valid", {31'b0, oID_valid}, 32'd0);
    chk("rst_inst", oID_inst, 32'd0);
    chk("rst_pc", oID_pc, 32'd0);
    rst = 1'b1;
    tick();
    chk("first_req_en", {31'b0, oMC_en}, 32'd1);
    serve(32'h0, 32'h00000013, 5);
    consume(1'b0, 32'h0);
    serve(32'h4, 32'h00400093, 2);
    consume(1'b0, 32'h0);
    serve(32'h8, 32'h00800113, 1);
    consume(1'b0, 32'h0);

    // redirect in the same cycle as done: result dropped, straight to IDLE
    wait_en(20);
    chk("req_12", oMC_addr, 32'hc);
    iMC_done = 1'b1; iMC_inst = 32'hdeadbeef; iJP_en = 1'b1; iJP_pc = 32'h40;
    tick();
    iMC_done = 1'b0; iMC_inst = '0; iJP_en = 1'b0;
    chk("jp_done_en", {31'b0, oMC_en}, 32'd0);
    chk("jp_done_valid", {31'b0, oID_valid}, 32'd0);
    tick();
    chk("req40_en", {31'b0, oMC_en}, 32'd1);
    chk("req40_addr", oMC_addr, 32'h40);
    tick();
    iJP_en = 1'b1; iJP_pc = 32'h200;
    tick();
    iJP_en = 1'b0;
    repeat (3) begin
      chk("discard_en", {31'b0, oMC_en}, 32'd1);
      chk("discard_addr", oMC_addr, 32'h40);
      chk("discard_valid", {31'b0, oID_valid}, 32'd0);
      tick();
    end
    iMC_done = 1'b1; iMC_inst = 32'h11111111;
    tick();
    iMC_done = 1'b0; iMC_inst = '0;
    chk("discard_end_en", {31'b0, oMC_en}, 32'd0);
    chk("discard_end_valid", {31'b0, oID_valid}, 32'd0);
    serve(32'h200, 32'h20000013, 3);

    // stall in HOLD, then taken prediction
    repeat (3) begin
      chk("stall_valid", {31'b0, oID_valid}, 32'd1);
      chk("stall_inst", oID_inst, 32'h20000013);
      chk("stall_pc", oID_pc, 32'h200);
      chk("stall_no_req", {31'b0, oMC_en}, 32'd0);
      tick();
    end
    consume(1'b1, 32'h80);
    serve(32'h80, 32'h08000013, 2);
    consume(1'b0, 32'h0);

    // redirect back to 0 from IDLE
    iJP_en = 1'b1; iJP_pc = 32'h0;
    tick();
    iJP_en = 1'b0;
    chk("redir0_valid", {31'b0, oID_valid}, 32'd0);
    chk("redir0_en", {31'b0, oMC_en}, 32'd0);
`ifdef ICACHE_EN
    sb.push_back('{pc: 32'h0, inst: 32'h00000013});
    tick();
    chk("hit_no_req", {31'b0, oMC_en}, 32'd0);
`else
    serve(32'h0, 32'h00000013, 2);
`endif
    chk("redir0_hold", {31'b0, oID_valid}, 32'd1);
    chk("redir0_sb", {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("redir0_inst", oID_inst, e.inst);
      chk("redir0_pc", oID_pc, e.pc);
    end
    // redirect with ready: not consumed, fetch continues at the target
    iID_ready = 1'b1; iJP_en = 1'b1; iJP_pc = 32'h100;
    tick();
    iID_ready = 1'b0; iJP_en = 1'b0;
    chk("redir100_valid", {31'b0, oID_valid}, 32'd0);
    serve(32'h100, 32'h10000013, 2);
    consume(1'b0, 32'h0);

    // reset during a miss
    wait_en(20);
    chk("req_104", oMC_addr, 32'h104);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_en", {31'b0, oMC_en}, 32'd0);
    chk("midrst_valid", {31'b0, oID_valid}, 32'd0);
    chk("midrst_addr", oMC_addr, 32'd0);
    chk("midrst_pc", oID_pc, 32'd0);
    tick();
    chk("postrst_en", {31'b0, oMC_en}, 32'd1);
    chk("postrst_addr", oMC_addr, 32'h0);

    // rdy=0 freezes everything, including a redirect
    tick();
    rdy = 1'b0; iJP_en = 1'b1; iJP_pc = 32'h300;
    repeat (3) begin
      tick();
      chk("frz_en", {31'b0, oMC_en}, 32'd1);
      chk("frz_addr", oMC_addr, 32'h0);
      chk("frz_valid", {31'b0, oID_valid}, 32'd0);
    end
    rdy = 1'b1; iJP_en = 1'b0; iJP_pc = '0;
    serve(32'h0, 32'h00000013, 2);
    consume(1'b0, 32'h0);
    wait_en(20);
    chk("after_frz_addr", oMC_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
